// File: rtl/multiboot_ctrl_pkg.sv
// Shared constants for the multiboot controller: state encoding, default
// register numbers, boot address width and a write-decode helper.
package multiboot_ctrl_pkg;

  localparam int unsigned ADDR_W = 24;

  localparam logic [7:0] DEF_COREADDR_REG = 8'hFC;
  localparam logic [7:0] DEF_COREBOOT_REG = 8'h0D;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;
  localparam logic [1:0] ST_LOCK = 2'd3;

  // True when the current host access is a write to the given register.
  function automatic logic is_write(input logic wr, input logic [7:0] addr,
                                    input logic [7:0] target);
    return wr && (addr == target);
  endfunction

endpackage

// File: rtl/multiboot_ctrl_if.sv
// Host register bus plus the boot outputs toward the ICAP sequencer.
interface multiboot_ctrl_if;
  import multiboot_ctrl_pkg::*;

  logic [7:0]        reg_addr;
  logic              reg_wr;
  logic [7:0]        din;
  logic [ADDR_W-1:0] spi_addr;
  logic              mbt_reboot;
  logic              busy;
  logic              addr_valid;

  modport master (
    output reg_addr, reg_wr, din,
    input  spi_addr, mbt_reboot, busy, addr_valid
  );

  modport slave (
    input  reg_addr, reg_wr, din,
    output spi_addr, mbt_reboot, busy, addr_valid
  );

endinterface

// File: rtl/multiboot_delay.sv
// Loadable down-counter that stops at zero and reports a zero flag.
module multiboot_delay #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  // Load has priority; otherwise count down while enabled, holding at zero.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/multiboot_ctrl.sv
// Multiboot controller: collects a 24-bit boot address from host writes,
// arms on a boot command, and after a fixed delay issues one reboot pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | collecting address bytes, waiting for a boot command
// ARM   | delay running; a boot write with din[0]=0 aborts
// FIRE  | one cycle, mbt_reboot high
// LOCK  | terminal until reset; all writes ignored
module multiboot_ctrl
  import multiboot_ctrl_pkg::*;
#(
  parameter logic [7:0]  COREADDR_REG = DEF_COREADDR_REG,
  parameter logic [7:0]  COREBOOT_REG = DEF_COREBOOT_REG,
  parameter int unsigned ARM_CYCLES   = 16
) (
  input  logic             clock,
  input  logic             reset,
  multiboot_ctrl_if.slave  bus
);

  if (COREADDR_REG == COREBOOT_REG) begin : g_reg_clash
    $error("multiboot_ctrl: COREADDR_REG and COREBOOT_REG must differ");
  end

  if ((ARM_CYCLES < 1) || (ARM_CYCLES > 255)) begin : g_arm_range
    $error("multiboot_ctrl: ARM_CYCLES must be in 1..255");
  end

  localparam logic [7:0] ARM_LOAD = 8'(ARM_CYCLES - 1);

  logic [1:0]        rst_sync_q;
  logic              rst_int;
  logic [1:0]        state_q;
  logic [ADDR_W-1:0] spi_addr_q;
  logic [1:0]        byte_cnt_q;
  logic              addr_valid_q;
  logic              busy_q;
  logic              reboot_q;
  logic              addr_wr;
  logic              boot_wr;
  logic              trigger;
  logic              abort;
  logic              cnt_zero;

  // Reset asserts immediately and releases two clock edges after reset drops,
  // so the state machine never sees a partially released reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_q[1];

  assign addr_wr = is_write(bus.reg_wr, bus.reg_addr, COREADDR_REG);
  assign boot_wr = is_write(bus.reg_wr, bus.reg_addr, COREBOOT_REG);
  assign trigger = (state_q == ST_IDLE) && boot_wr && bus.din[0] && addr_valid_q;
  assign abort   = (state_q == ST_ARM) && boot_wr && !bus.din[0];

  multiboot_delay #(
    .WIDTH (8)
  ) u_delay (
    .clock    (clock),
    .rst      (rst_int),
    .load     (trigger),
    .load_val (ARM_LOAD),
    .en       (state_q == ST_ARM),
    .zero     (cnt_zero)
  );

  // Sequencing FSM with all outputs registered; abort wins over firing.
  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      state_q      <= ST_IDLE;
      spi_addr_q   <= '0;
      byte_cnt_q   <= 2'd0;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      reboot_q     <= 1'b0;
    end else begin
      reboot_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (addr_wr) begin
            spi_addr_q <= {spi_addr_q[ADDR_W-9:0], bus.din};
            if (byte_cnt_q != 2'd3) begin
              byte_cnt_q   <= byte_cnt_q + 2'd1;
              addr_valid_q <= (byte_cnt_q == 2'd2);
            end
          end else if (trigger) begin
            state_q <= ST_ARM;
            busy_q  <= 1'b1;
          end
        end
        ST_ARM: begin
          if (abort) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= 2'd0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end else if (cnt_zero) begin
            state_q  <= ST_FIRE;
            reboot_q <= 1'b1;
          end
        end
        ST_FIRE: begin
          state_q <= ST_LOCK;
        end
        ST_LOCK: begin
          state_q <= ST_LOCK;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.spi_addr   = spi_addr_q;
  assign bus.mbt_reboot = reboot_q;
  assign bus.busy       = busy_q;
  assign bus.addr_valid = addr_valid_q;

endmodule

// File: tb/tb_multiboot_ctrl.sv
// Directed and randomized checks of multiboot_ctrl against a cycle-level
// behavioural model of the boot sequence.
module tb_multiboot_ctrl;

  localparam int         ARM     = 16;
  localparam logic [7:0] R_ADDR  = 8'hFC;
  localparam logic [7:0] R_BOOT  = 8'h0D;

  logic clock = 1'b0;
  logic reset = 1'b1;

  multiboot_ctrl_if bus ();

  multiboot_ctrl #(
    .COREADDR_REG (R_ADDR),
    .COREBOOT_REG (R_BOOT),
    .ARM_CYCLES   (ARM)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int trig_cyc  = 0;

  // Reference model: address shift register, bytes loaded, and the edge
  // index at which the armed boot is due.
  logic [23:0] m_spi;
  int          m_bytes;
  bit          m_armed;
  bit          m_done;
  int          m_fire_at;
  bit          m_pulse;

  task automatic model_reset();
    m_spi = 24'h0; m_bytes = 0; m_armed = 0; m_done = 0;
    m_fire_at = 0; m_pulse = 0;
  endtask

  task automatic model_step(input logic wr, input logic [7:0] a, input logic [7:0] d);
    m_pulse = 0;
    if (m_armed) begin
      if (wr && a == R_BOOT && !d[0]) begin
        m_armed = 0; m_bytes = 0;
      end else if (cyc == m_fire_at) begin
        m_armed = 0; m_done = 1; m_pulse = 1;
      end
    end else if (!m_done) begin
      if (wr && a == R_ADDR) begin
        m_spi = {m_spi[15:0], d};
        if (m_bytes < 3) m_bytes++;
      end else if (wr && a == R_BOOT && d[0] && m_bytes == 3) begin
        m_armed = 1; m_fire_at = cyc + ARM;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".spi_addr"},   32'(bus.spi_addr),   32'(m_spi));
    chk({tag, ".busy"},       32'(bus.busy),       32'(m_armed | m_done));
    chk({tag, ".addr_valid"}, 32'(bus.addr_valid), 32'(m_bytes == 3));
    chk({tag, ".reboot"},     32'(bus.mbt_reboot), 32'(m_pulse));
  endtask

  task automatic cycle(input string tag, input logic wr, input logic [7:0] a, input logic [7:0] d);
    bus.reg_wr = wr; bus.reg_addr = a; bus.din = d;
    @(posedge clock);
    cyc++;
    model_step(wr, a, d);
    #1;
    bus.reg_wr = 1'b0;
    chk_outputs(tag);
    if (bus.mbt_reboot === 1'b1) begin
      pulse_cnt++;
      pulse_cyc = cyc;
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 8'h00, 8'h00);
  endtask

  // Reset is asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_outputs({tag, ".async"});
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    idle({tag, ".release"}, 3);
    pulse_cnt = 0;
  endtask

  task automatic load3(input string tag, input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
    cycle(tag, 1'b1, R_ADDR, b2);
    cycle(tag, 1'b1, R_ADDR, b1);
    cycle(tag, 1'b1, R_ADDR, b0);
  endtask

  task automatic fire_cmd(input string tag, input logic [7:0] d);
    cycle(tag, 1'b1, R_BOOT, d);
    trig_cyc = cyc;
  endtask

  initial begin
    bus.reg_wr = 1'b0; bus.reg_addr = 8'h00; bus.din = 8'h00;
    model_reset();
    #3;
    chk("reset.spi_addr",   32'(bus.spi_addr),   32'h0);
    chk("reset.busy",       32'(bus.busy),       32'h0);
    chk("reset.addr_valid", 32'(bus.addr_valid), 32'h0);
    chk("reset.reboot",     32'(bus.mbt_reboot), 32'h0);
    @(posedge clock);
    #3 reset = 1'b0;
    idle("release", 3);

    // Basic boot: address 0x058000, pulse 16 edges after the trigger.
    load3("basic.load", 8'h05, 8'h80, 8'h00);
    chk("basic.addr", 32'(bus.spi_addr), 32'h058000);
    fire_cmd("basic.trig", 8'h01);
    chk("basic.busy_next", 32'(bus.busy), 32'h1);
    idle("basic.wait", ARM + 3);
    chk("basic.pulse_cnt", 32'(pulse_cnt), 32'd1);
    chk("basic.pulse_at", 32'(pulse_cyc - trig_cyc), 32'(ARM));
    chk("basic.busy_after", 32'(bus.busy), 32'h1);

    // Post-pulse writes change nothing and give no second pulse.
    load3("lock.load", 8'h11, 8'h22, 8'h33);
    fire_cmd("lock.trig", 8'h01);
    idle("lock.wait", ARM + 3);
    chk("lock.pulse_cnt", 32'(pulse_cnt), 32'd1);
    chk("lock.addr", 32'(bus.spi_addr), 32'h058000);

    // Two bytes only: boot command ignored.
    do_reset("short");
    cycle("short.load", 1'b1, R_ADDR, 8'hAA);
    cycle("short.load", 1'b1, R_ADDR, 8'hBB);
    fire_cmd("short.trig", 8'h01);
    idle("short.wait", ARM + 3);
    chk("short.busy", 32'(bus.busy), 32'h0);
    chk("short.addr_valid", 32'(bus.addr_valid), 32'h0);
    chk("short.pulse_cnt", 32'(pulse_cnt), 32'd0);

    // Abort five cycles after trigger.
    do_reset("abort");
    load3("abort.load", 8'h01, 8'h02, 8'h03);
    fire_cmd("abort.trig", 8'h01);
    idle("abort.gap", 4);
    cycle("abort.cmd", 1'b1, R_BOOT, 8'h00);
    chk("abort.busy", 32'(bus.busy), 32'h0);
    chk("abort.addr_valid", 32'(bus.addr_valid), 32'h0);
    idle("abort.wait", ARM + 10);
    chk("abort.pulse_cnt", 32'(pulse_cnt), 32'd0);

    // Address write and repeat boot-1 during ARM: ignored, pulse on schedule.
    do_reset("hold");
    load3("hold.load", 8'h12, 8'h34, 8'h56);
    fire_cmd("hold.trig", 8'h01);
    idle("hold.gap", 2);
    cycle("hold.addr", 1'b1, R_ADDR, 8'hFF);
    cycle("hold.reboot1", 1'b1, R_BOOT, 8'h01);
    cycle("hold.other", 1'b1, 8'h42, 8'h00);
    chk("hold.addr", 32'(bus.spi_addr), 32'h123456);
    idle("hold.wait", ARM);
    chk("hold.pulse_cnt", 32'(pulse_cnt), 32'd1);
    chk("hold.pulse_at", 32'(pulse_cyc - trig_cyc), 32'(ARM));

    // Reset three cycles after trigger, then a full reload gives one pulse.
    do_reset("rst3");
    load3("rst3.load", 8'h0A, 8'h0B, 8'h0C);
    fire_cmd("rst3.trig", 8'h01);
    idle("rst3.gap", 3);
    do_reset("rst3.rst");
    idle("rst3.quiet", ARM + 3);
    chk("rst3.no_pulse", 32'(pulse_cnt), 32'd0);
    load3("rst3.reload", 8'h0A, 8'h0B, 8'h0C);
    fire_cmd("rst3.retrig", 8'h01);
    idle("rst3.wait", ARM + 3);
    chk("rst3.pulse_cnt", 32'(pulse_cnt), 32'd1);

    // Reset while the pulse is high drops it at once.
    do_reset("inflight");
    load3("inflight.load", 8'h77, 8'h66, 8'h55);
    fire_cmd("inflight.trig", 8'h01);
    idle("inflight.wait", ARM);
    chk("inflight.pulse_up", 32'(bus.mbt_reboot), 32'h1);
    do_reset("inflight.rst");

    // Randomized host traffic against the model.
    for (int r = 0; r < 6; r++) begin
      do_reset("rand");
      for (int i = 0; i < 80; i++) begin
        logic [7:0] a;
        logic [7:0] d;
        logic       wr;
        int         sel;
        sel = int'($urandom_range(0, 5));
        d   = 8'($urandom);
        wr  = 1'b1;
        case (sel)
          0, 1:    a = R_ADDR;
          2: begin a = R_BOOT; d[0] = ($urandom_range(0, 3) != 0); end
          3:       a = 8'h20 + 8'($urandom_range(0, 15));
          default: begin a = R_ADDR; wr = 1'b0; end
        endcase
        if (sel == 4 && ($urandom_range(0, 1) == 1)) begin
          a = R_BOOT; d[0] = 1'b1; wr = 1'b1;
        end
        cycle("rand", wr, a, d);
      end
      chk("rand.pulses_le1", 32'(pulse_cnt <= 1), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
